// File: rtl/dac_thermo_decoder.sv
// 2-bit code to 3 unit-element selects, held for SETTLE_CYCLES after each update.
// Optional macro DAC_DEM_EN rotates the element choice with a pointer (dynamic element matching).
module dac_thermo_decoder #(
    parameter int SETTLE_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in1,
    input  logic in2,
    input  logic in_valid,
    output logic in_ready,
    output logic out1,
    output logic out2,
    output logic out3,
    output logic out4,
    output logic out_valid
);

    typedef enum logic {IDLE, SETTLE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] elem_q, elem_d;
    logic       seen_q, seen_d;
    logic [1:0] code;
    logic [2:0] therm;
    logic [2:0] sel;
    logic       accept;

`ifdef DAC_DEM_EN
    logic [1:0] ptr_q, ptr_d;
    logic [5:0] rot;
    logic [2:0] psum;

    // Doubling the pattern lets a plain left shift act as a 3-bit rotate.
    always_comb begin
        rot   = {therm, therm} << ptr_q;
        sel   = rot[5:3];
        psum  = {1'b0, ptr_q} + {1'b0, code};
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = (psum >= 3'd3) ? 2'(psum - 3'd3) : psum[1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        sel = therm;
    end
`endif

    always_comb begin
        code   = {in2, in1};
        accept = (state_q == IDLE) && in_valid;
        case (code)
            2'd0:    therm = 3'b000;
            2'd1:    therm = 3'b001;
            2'd2:    therm = 3'b011;
            default: therm = 3'b111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        elem_d  = elem_q;
        seen_d  = seen_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETTLE;
                    cnt_d   = CNT_LOAD;
                    elem_d  = sel;
                    seen_d  = 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            elem_q  <= 3'b000;
            seen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            elem_q  <= elem_d;
            seen_q  <= seen_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == IDLE) && seen_q;
    assign out1      = 1'b0;
    assign out2      = elem_q[0];
    assign out3      = elem_q[1];
    assign out4      = elem_q[2];

endmodule

// File: tb/tb_dac_thermo_decoder.sv
// Directed bench for dac_thermo_decoder: SETTLE_CYCLES=3 instance plus a SETTLE_CYCLES=1 instance.
module tb_dac_thermo_decoder;

    localparam int S_A = 3;
    localparam int S_B = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic a_in1, a_in2, a_vld;
    logic a_rdy, a_o1, a_o2, a_o3, a_o4, a_ov;
    logic b_in1, b_in2, b_vld;
    logic b_rdy, b_o1, b_o2, b_o3, b_o4, b_ov;

    dac_thermo_decoder #(.SETTLE_CYCLES(S_A)) u_a (
        .clk(clk), .rst(rst), .in1(a_in1), .in2(a_in2), .in_valid(a_vld),
        .in_ready(a_rdy), .out1(a_o1), .out2(a_o2), .out3(a_o3), .out4(a_o4),
        .out_valid(a_ov)
    );

    dac_thermo_decoder #(.SETTLE_CYCLES(S_B)) u_b (
        .clk(clk), .rst(rst), .in1(b_in1), .in2(b_in2), .in_valid(b_vld),
        .in_ready(b_rdy), .out1(b_o1), .out2(b_o2), .out3(b_o3), .out4(b_o4),
        .out_valid(b_ov)
    );

    int checks   = 0;
    int failures = 0;
    logic [2:0] exp_q[$];
    logic [2:0] b_q[$];
    int p_model = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Element i maps to bit i; out2 is element 0.
    function automatic logic [2:0] model_sel(input int n, input int p);
        logic [2:0] e;
        e = 3'b000;
        for (int i = 0; i < n; i++) begin
`ifdef DAC_DEM_EN
            e[(p + i) % 3] = 1'b1;
`else
            e[i] = 1'b1;
`endif
        end
        return e;
    endfunction

    function automatic logic [3:0] a_outs();
        return {a_o4, a_o3, a_o2, a_o1};
    endfunction

    // Accepts one code on instance A, then follows the settle period.
    // keep_vld holds in_valid high with scrambled data; otherwise in_valid toggles with code 0.
    task automatic a_accept(input int code, input bit keep_vld);
        int n;
        logic [2:0] e;
        logic [3:0] held;
        n = 0;
        while (a_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a_rdy_before_accept", a_rdy, 1);
        a_in1 = code[0];
        a_in2 = code[1];
        a_vld = 1'b1;
        exp_q.push_back(model_sel(code, p_model));
        p_model = (p_model + code) % 3;
        @(posedge clk);
        #1;
        chk("a_out_at_accept_edge", a_outs(), {exp_q[0], 1'b0});
        chk("a_rdy_low_after_accept", a_rdy, 0);
        chk("a_valid_low_in_settle", a_ov, 0);
        held = a_outs();
        n = 0;
        while (a_rdy !== 1'b1 && n < 20) begin
            if (keep_vld) begin
                a_in1 = ~code[0];
                a_in2 = ~code[1];
            end else begin
                a_in1 = 1'b0;
                a_in2 = 1'b0;
                a_vld = ~a_vld;
            end
            @(posedge clk);
            #1;
            n++;
            chk("a_out_stable_in_settle", a_outs(), held);
        end
        if (!keep_vld) a_vld = 1'b0;
        chk("a_settle_length", n, S_A);
        e = exp_q.pop_front();
        chk("a_out_settled", a_outs(), {e, 1'b0});
        chk("a_out_valid_idle", a_ov, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] e;
        rst = 1'b1;
        a_in1 = 0; a_in2 = 0; a_vld = 0;
        b_in1 = 0; b_in2 = 0; b_vld = 0;
        #2;
        chk("rst_in_ready", a_rdy, 1);
        chk("rst_outs", a_outs(), 4'b0000);
        chk("rst_out_valid", a_ov, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_outs", a_outs(), 4'b0000);
        chk("idle_out_valid", a_ov, 0);
        chk("idle_in_ready", a_rdy, 1);

        // Back-to-back codes with in_valid held high.
        a_accept(1, 1'b1);
        a_accept(2, 1'b1);
        a_accept(3, 1'b1);
        // Code 0 with in_valid toggling during settle.
        a_accept(0, 1'b0);
        repeat (3) @(negedge clk);
        chk("no_extra_accept_rdy", a_rdy, 1);
        chk("no_extra_accept_outs", a_outs(), 4'b0000);

        // Pointer sequence: rotates under DEM, plain thermometer otherwise.
        a_accept(2, 1'b0);
        a_accept(2, 1'b0);
        a_accept(1, 1'b0);
        a_accept(3, 1'b0);
        a_accept(1, 1'b0);

        // Reset pulse one cycle after accepting code 3.
        @(negedge clk);
        a_in1 = 1; a_in2 = 1; a_vld = 1;
        @(posedge clk);
        #1;
        a_vld = 0;
        chk("pre_rst_busy", a_rdy, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_settle_rst_outs", a_outs(), 4'b0000);
        chk("mid_settle_rst_valid", a_ov, 0);
        chk("mid_settle_rst_rdy", a_rdy, 1);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        p_model = 0;
        a_accept(1, 1'b0);
        chk("post_rst_out2", a_o2, 1);

        // Instance B, SETTLE_CYCLES=1: code 3 then code 0 with in_valid held.
        @(negedge clk);
        b_in1 = 1; b_in2 = 1; b_vld = 1;
        b_q.push_back(model_sel(3, 0));
        @(posedge clk);
        #1;
        b_in1 = 0; b_in2 = 0;
        b_q.push_back(model_sel(0, 0));
        chk("b_valid_low_1", b_ov, 0);
        chk("b_rdy_low_1", b_rdy, 0);
        @(posedge clk);
        #1;
        e = b_q.pop_front();
        chk("b_valid_high_1", b_ov, 1);
        chk("b_outs_code3", {b_o4, b_o3, b_o2, b_o1}, {e, 1'b0});
        @(posedge clk);
        #1;
        b_vld = 0;
        chk("b_valid_low_2", b_ov, 0);
        @(posedge clk);
        #1;
        e = b_q.pop_front();
        chk("b_valid_high_2", b_ov, 1);
        chk("b_rdy_high_2", b_rdy, 1);
        chk("b_outs_code0", {b_o4, b_o3, b_o2, b_o1}, {e, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
